// File: rtl/pmp_seq_checker.sv
// Time-multiplexed PMP permission checker: one entry examined per clock, lowest index wins.
// Trades latency (up to NENT cycles) for a single shared address comparator.
module pmp_seq_checker #(
    parameter int unsigned NENT = 8,
    localparam int unsigned IW  = (NENT > 1) ? $clog2(NENT) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_req_valid,
    output logic               io_req_ready,
    input  logic [31:0]        io_req_addr,
    input  logic [1:0]         io_req_prv,
    input  logic               io_kill,
    input  logic [NENT*6-1:0]  io_pmp_cfg,
    input  logic [NENT*30-1:0] io_pmp_addr,
    input  logic [NENT*32-1:0] io_pmp_mask,
    output logic               io_resp_valid,
    input  logic               io_resp_ready,
    output logic               io_resp_r,
    output logic               io_resp_w,
    output logic               io_resp_x,
    output logic               io_resp_hit,
    output logic [IW-1:0]      io_resp_idx
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [31:0]   addr_q;
    logic [1:0]    prv_q;

    logic [5:0]  cfg_arr  [NENT];
    logic [31:0] base_arr [NENT];
    logic [31:0] mask_arr [NENT];

    logic [5:0]  cur_cfg;
    logic [31:0] cur_base;
    logic [31:0] cur_mask;
    logic [31:0] prev_base;
    logic        match_c;
    logic        last_c;
    logic        mprv_c;

    // Unpack the flat CSR buses into per-entry views.
    always_comb begin
        for (int unsigned e = 0; e < NENT; e++) begin
            cfg_arr[e]  = io_pmp_cfg[6*e +: 6];
            base_arr[e] = {io_pmp_addr[30*e +: 30], 2'b00};
            mask_arr[e] = io_pmp_mask[32*e +: 32];
        end
    end

    // Match logic for the entry currently selected by idx; cfg = {l, a[1:0], x, w, r}.
    always_comb begin
        cur_cfg   = cfg_arr[idx];
        cur_base  = base_arr[idx];
        cur_mask  = mask_arr[idx];
        prev_base = (idx == '0) ? 32'd0 : base_arr[idx - IW'(1)];
        match_c   = 1'b0;
        case (cur_cfg[4:3])
            2'b00:   match_c = 1'b0;
            2'b01:   match_c = (addr_q >= prev_base) && (addr_q < cur_base);
            default: match_c = ((addr_q ^ cur_base) & ~cur_mask) == 32'd0;
        endcase
        last_c = (idx == IW'(NENT - 1));
        mprv_c = (prv_q > 2'd1);
    end

    assign io_req_ready  = (state == IDLE);
    assign io_resp_valid = (state == RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            addr_q      <= 32'd0;
            prv_q       <= 2'd0;
            io_resp_r   <= 1'b0;
            io_resp_w   <= 1'b0;
            io_resp_x   <= 1'b0;
            io_resp_hit <= 1'b0;
            io_resp_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Kill is ignored here: a presented request is always taken.
                    if (io_req_valid) begin
                        addr_q <= io_req_addr;
                        prv_q  <= io_req_prv;
                        idx    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (io_kill) begin
                        state       <= IDLE;
                        idx         <= '0;
                        io_resp_r   <= 1'b0;
                        io_resp_w   <= 1'b0;
                        io_resp_x   <= 1'b0;
                        io_resp_hit <= 1'b0;
                        io_resp_idx <= '0;
                    end else if (match_c) begin
                        io_resp_r   <= cur_cfg[0] | (mprv_c & ~cur_cfg[5]);
                        io_resp_w   <= cur_cfg[1] | (mprv_c & ~cur_cfg[5]);
                        io_resp_x   <= cur_cfg[2] | (mprv_c & ~cur_cfg[5]);
                        io_resp_hit <= 1'b1;
                        io_resp_idx <= idx;
                        state       <= RESP;
                    end else if (last_c) begin
                        io_resp_r   <= mprv_c;
                        io_resp_w   <= mprv_c;
                        io_resp_x   <= mprv_c;
                        io_resp_hit <= 1'b0;
                        io_resp_idx <= '0;
                        state       <= RESP;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                RESP: begin
                    if (io_kill || io_resp_ready) begin
                        state       <= IDLE;
                        idx         <= '0;
                        io_resp_r   <= 1'b0;
                        io_resp_w   <= 1'b0;
                        io_resp_x   <= 1'b0;
                        io_resp_hit <= 1'b0;
                        io_resp_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Bench for pmp_seq_checker: directed corner cases plus random traffic against a
// first-match reference model computed straight from the PMP matching rules.
module tb_pmp_seq_checker;

    localparam int NENT = 8;
    localparam int IW   = 3;

    logic                clock;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [31:0]         req_addr;
    logic [1:0]          req_prv;
    logic                kill;
    logic [NENT*6-1:0]   pmp_cfg;
    logic [NENT*30-1:0]  pmp_addr;
    logic [NENT*32-1:0]  pmp_mask;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_r;
    logic                resp_w;
    logic                resp_x;
    logic                resp_hit;
    logic [IW-1:0]       resp_idx;

    logic [5:0]  cfg [NENT];
    logic [29:0] pa  [NENT];
    logic [31:0] mk  [NENT];

    int total;
    int bad;

    logic        obs_hit, obs_r, obs_w, obs_x;
    int          obs_idx, obs_lat;

    pmp_seq_checker #(.NENT(NENT)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (req_valid),
        .io_req_ready (req_ready),
        .io_req_addr  (req_addr),
        .io_req_prv   (req_prv),
        .io_kill      (kill),
        .io_pmp_cfg   (pmp_cfg),
        .io_pmp_addr  (pmp_addr),
        .io_pmp_mask  (pmp_mask),
        .io_resp_valid(resp_valid),
        .io_resp_ready(resp_ready),
        .io_resp_r    (resp_r),
        .io_resp_w    (resp_w),
        .io_resp_x    (resp_x),
        .io_resp_hit  (resp_hit),
        .io_resp_idx  (resp_idx)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int e = 0; e < NENT; e++) begin
            pmp_cfg[6*e +: 6]   = cfg[e];
            pmp_addr[30*e +: 30] = pa[e];
            pmp_mask[32*e +: 32] = mk[e];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // First matching entry wins; M-mode without lock gets full access, default is prv>1.
    task automatic model(input logic [31:0] a, input logic [1:0] p, output logic h,
                         output int idx, output logic r, output logic w, output logic x);
        longint unsigned addr, lo, base;
        logic m, ovr;
        addr = 64'(a);
        h = 1'b0; idx = 0;
        r = (p > 2'd1); w = r; x = r;
        for (int e = 0; e < NENT; e++) begin
            base = 64'({pa[e], 2'b00});
            lo   = 0;
            if (e > 0) lo = 64'({pa[e-1], 2'b00});
            case (cfg[e][4:3])
                2'b00:   m = 1'b0;
                2'b01:   m = (addr >= lo) && (addr < base);
                default: m = ((a ^ {pa[e], 2'b00}) & ~mk[e]) == 32'd0;
            endcase
            if (m) begin
                ovr = (p > 2'd1) && !cfg[e][5];
                h = 1'b1; idx = e;
                r = cfg[e][0] | ovr; w = cfg[e][1] | ovr; x = cfg[e][2] | ovr;
                break;
            end
        end
    endtask

    task automatic clear_cfg();
        for (int e = 0; e < NENT; e++) begin
            cfg[e] = 6'd0; pa[e] = 30'd0; mk[e] = 32'd0;
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [1:0] p, input logic kidle);
        @(negedge clock);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_addr = a; req_prv = p; req_valid = 1'b1; kill = kidle;
        @(posedge clock);
        #1;
        req_valid = 1'b0; kill = 1'b0;
        req_addr = $urandom; req_prv = 2'($urandom);
    endtask

    // Counts clock edges after the handshake until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        @(negedge clock);
        while (!resp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [1:0] p, input int stall,
                           input logic kidle);
        logic eh, er, ew, ex;
        int ei;
        model(a, p, eh, ei, er, ew, ex);
        start_req(a, p, kidle);
        wait_resp(obs_lat);
        obs_hit = resp_hit; obs_r = resp_r; obs_w = resp_w; obs_x = resp_x;
        obs_idx = int'(resp_idx);
        chk("latency", 32'(obs_lat), 32'(eh ? ei + 1 : NENT));
        chk("hit", 32'(resp_hit), 32'(eh));
        chk("idx", 32'(resp_idx), 32'(eh ? ei : 0));
        chk("rwx", 32'({resp_r, resp_w, resp_x}), 32'({er, ew, ex}));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_out", 32'({resp_hit, resp_r, resp_w, resp_x, resp_idx}),
                32'({obs_hit, obs_r, obs_w, obs_x, IW'(obs_idx)}));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("post_accept_valid", 32'(resp_valid), 32'd0);
        chk("post_accept_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic set_t1();
        clear_cfg();
        cfg[0] = 6'b111101;
        pa[0]  = 30'h2000_0000;
        mk[0]  = 32'h0000_0FFF;
    endtask

    initial begin
        int lat, cnt, j, sel;
        logic [31:0] a, b;
        total = 0; bad = 0;
        clock = 1'b0; reset = 1'b1;
        req_valid = 1'b0; req_addr = 32'd0; req_prv = 2'd0;
        kill = 1'b0; resp_ready = 1'b0;
        clear_cfg();
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'({resp_valid, resp_hit, resp_r, resp_w, resp_x, resp_idx}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // NAPOT hit on entry 0, locked, U-mode.
        set_t1();
        run_req(32'h8000_0ABC, 2'd0, 1, 1'b0);
        chk("t1_fields", 32'({obs_hit, obs_r, obs_w, obs_x}), 32'b1101);
        chk("t1_idx_lat", 32'({obs_idx[7:0], obs_lat[7:0]}), 32'h0001);

        // All OFF: default by privilege, full-length scan.
        clear_cfg();
        run_req(32'h1234_5678, 2'd3, 0, 1'b0);
        chk("t2_m", 32'({obs_hit, obs_r, obs_w, obs_x, obs_lat[7:0]}), 32'({4'b0111, 8'd8}));
        run_req(32'h1234_5678, 2'd0, 0, 1'b0);
        chk("t2_u", 32'({obs_hit, obs_r, obs_w, obs_x}), 32'b0000);

        // TOR on entry 2 with bounds from entries 1 and 2.
        clear_cfg();
        cfg[2] = 6'b001001; pa[1] = 30'h400; pa[2] = 30'h800;
        run_req(32'h0000_1FFC, 2'd3, 0, 1'b0);
        chk("t3_in", 32'({obs_hit, obs_r, obs_w, obs_x, obs_idx[3:0]}), 32'h0F2);
        run_req(32'h0000_2000, 2'd3, 0, 1'b0);
        chk("t3_top", 32'(obs_hit), 32'd0);

        // TOR entry 0 with base 0 never matches, even near the top of the space.
        clear_cfg();
        cfg[0] = 6'b001111;
        run_req(32'hFFFF_FFFC, 2'd0, 0, 1'b0);
        chk("tor_nowrap", 32'({obs_hit, obs_r, obs_w, obs_x}), 32'd0);

        // Overlap: lower index wins; long stall on the response.
        clear_cfg();
        cfg[3] = 6'b111001; pa[3] = 30'h1000_0000; mk[3] = 32'h0000_00FF;
        cfg[5] = 6'b111011; pa[5] = 30'h1000_0000; mk[5] = 32'h0000_FFFF;
        run_req(32'h4000_0010, 2'd0, 4, 1'b0);
        chk("t4", 32'({obs_idx[3:0], obs_w, obs_lat[7:0]}), 32'({4'd3, 1'b0, 8'd4}));

        // Request with kill in IDLE: accepted, kill ignored.
        set_t1();
        run_req(32'h8000_0004, 2'd1, 0, 1'b1);

        // Kill mid-scan in cycle C+3.
        clear_cfg();
        start_req(32'h0000_0100, 2'd3, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        kill = 1'b1;
        @(posedge clock);
        #1 kill = 1'b0;
        @(negedge clock);
        chk("kill_ready", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (resp_valid) cnt++;
        end
        chk("kill_noresp", 32'(cnt), 32'd0);
        run_req(32'h0000_0100, 2'd3, 0, 1'b0);

        // Kill coincides with a hit on entry 0.
        set_t1();
        start_req(32'h8000_0000, 2'd0, 1'b0);
        kill = 1'b1;
        @(posedge clock);
        #1 kill = 1'b0;
        @(negedge clock);
        chk("killhit", 32'({resp_valid, resp_hit, req_ready}), 32'b001);

        // Kill while holding a response clears it.
        start_req(32'h8000_0000, 2'd0, 1'b0);
        wait_resp(lat);
        chk("killresp_lat", 32'(lat), 32'd1);
        kill = 1'b1;
        @(posedge clock);
        #1 kill = 1'b0;
        @(negedge clock);
        chk("killresp", 32'({resp_valid, resp_hit, resp_r, resp_w, resp_x, req_ready}), 32'b000001);

        // Async reset mid-scan.
        clear_cfg();
        start_req(32'h0000_0040, 2'd3, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_scan", 32'({resp_valid, req_ready}), 32'b01);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_scan_after", 32'({resp_valid, req_ready}), 32'b01);

        // Async reset while holding a response.
        set_t1();
        start_req(32'h8000_0FFC, 2'd0, 1'b0);
        wait_resp(lat);
        chk("rst_resp_pre", 32'(resp_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_resp", 32'({resp_valid, resp_hit, resp_r, resp_w, resp_x}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_resp_after", 32'({resp_valid, req_ready}), 32'b01);
        run_req(32'h8000_0FFC, 2'd0, 0, 1'b0);

        // Random traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            for (int e = 0; e < NENT; e++) begin
                cfg[e] = 6'($urandom);
                pa[e]  = 30'($urandom);
                mk[e]  = (32'd1 << $urandom_range(0, 14)) - 32'd1;
            end
            j   = $urandom_range(0, NENT - 1);
            sel = $urandom_range(0, 3);
            b   = {pa[j], 2'b00};
            case (sel)
                0:       a = b ^ (32'($urandom) & mk[j]);
                1:       a = b - 32'd4;
                2:       a = b;
                default: a = $urandom;
            endcase
            run_req(a, 2'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
